// File: rtl/serial_add_ctrl_if.sv
// Requester <-> bit-serial adder handshake bundle.
// OVF is present only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C_out;
`ifdef SERIAL_ADD_OVF_EN
  logic             OVF;

  modport master (output start, A, B, C_in, input busy, done, Sum, C_out, OVF);
  modport slave  (input start, A, B, C_in, output busy, done, Sum, C_out, OVF);
`else
  modport master (output start, A, B, C_in, input busy, done, Sum, C_out);
  modport slave  (input start, A, B, C_in, output busy, done, Sum, C_out);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one Full_Add cell adds two WIDTH-bit operands LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_ADD_OVF_EN.
module Full_Add (
  input  logic I1,
  input  logic I2,
  input  logic C_in,
  output logic S,
  output logic C_out
);
  assign S     = I1 ^ I2 ^ C_in;
  assign C_out = (I1 & I2) | (C_in & (I1 ^ I2));
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one result bit per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, result valid
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_add_ctrl_if.slave    bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             accept, last_bit;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q;
  logic             fa_s, fa_c;

  Full_Add u_fa (
    .I1   (a_sh[0]),
    .I2   (b_sh[0]),
    .C_in (carry_q),
    .S    (fa_s),
    .C_out(fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_BIT) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_sh    <= bus.A;
      b_sh    <= bus.B;
      carry_q <= bus.C_in;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry_q <= fa_c;
      sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
      // counter holds at WIDTH-1 so it never wraps for power-of-two widths
      if (!last_bit) cnt_q <= cnt_q + 1'b1;
      if (last_bit)  cout_q <= fa_c;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // carry_q during the last RUN cycle is the carry into the MSB
  always_ff @(posedge clk) begin
    if (rst || accept)                     ovf_q <= 1'b0;
    else if (state_q == RUN && last_bit)   ovf_q <= carry_q ^ fa_c;
  end

  assign bus.OVF = ovf_q;
`endif

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.Sum   = sum_q;
  assign bus.C_out = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=2,
// checked against an arithmetic reference (A+B+C_in).
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add_ctrl_if #(.WIDTH(2)) if2 ();

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_add_ctrl #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic dut_done(input bit narrow);
    return narrow ? if2.done : if8.done;
  endfunction

  function automatic logic dut_busy(input bit narrow);
    return narrow ? if2.busy : if8.busy;
  endfunction

  function automatic logic [31:0] dut_sum(input bit narrow);
    return narrow ? {30'd0, if2.Sum} : {24'd0, if8.Sum};
  endfunction

  function automatic logic dut_cout(input bit narrow);
    return narrow ? if2.C_out : if8.C_out;
  endfunction

`ifdef SERIAL_ADD_OVF_EN
  function automatic logic dut_ovf(input bit narrow);
    return narrow ? if2.OVF : if8.OVF;
  endfunction
`endif

  // One full operation, starting in an IDLE cycle; returns after done+1.
  task automatic run_op(input bit narrow, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input string tag);
    int          wid;
    logic [63:0] mask, full;
    logic [31:0] exp_sum;
    logic        exp_c, exp_ovf, a_msb, b_msb, s_msb;
    int          done_cyc;
    wid     = narrow ? 2 : 8;
    mask    = (64'd1 << wid) - 64'd1;
    full    = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
    exp_sum = 32'(full & mask);
    exp_c   = full[wid];
    a_msb   = a[wid-1];
    b_msb   = b[wid-1];
    s_msb   = exp_sum[wid-1];
    exp_ovf = (a_msb == b_msb) && (s_msb != a_msb);

    if (narrow) begin
      if2.start = 1'b1; if2.A = a[1:0]; if2.B = b[1:0]; if2.C_in = cin;
    end else begin
      if8.start = 1'b1; if8.A = a[7:0]; if8.B = b[7:0]; if8.C_in = cin;
    end
    tick();
    if2.start = 1'b0;
    if8.start = 1'b0;
    if (narrow) begin if2.A = '0; if2.B = '0; if2.C_in = 1'b0; end
    else        begin if8.A = '0; if8.B = '0; if8.C_in = 1'b0; end
    chk({tag, "_busy_c1"}, 64'(dut_busy(narrow)), 64'd1);

    done_cyc = 0;
    for (int c = 1; c <= wid + 4; c++) begin
      if (dut_done(narrow)) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    if (done_cyc == 0) begin
      chk({tag, "_done_timeout"}, 64'd0, 64'd1);
      return;
    end
    chk({tag, "_latency"}, 64'(done_cyc), 64'(wid + 1));
    chk({tag, "_busy_done"}, 64'(dut_busy(narrow)), 64'd1);
    chk({tag, "_sum"}, 64'(dut_sum(narrow)), 64'(exp_sum));
    chk({tag, "_cout"}, 64'(dut_cout(narrow)), 64'(exp_c));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 64'(dut_ovf(narrow)), 64'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    tick();
    chk({tag, "_busy_after"}, 64'(dut_busy(narrow)), 64'd0);
    chk({tag, "_done_after"}, 64'(dut_done(narrow)), 64'd0);
    chk({tag, "_sum_held"}, 64'(dut_sum(narrow)), 64'(exp_sum));
  endtask

  initial begin
    int dones, first_done, second_done;
    if8.start = 1'b0; if8.A = '0; if8.B = '0; if8.C_in = 1'b0;
    if2.start = 1'b0; if2.A = '0; if2.B = '0; if2.C_in = 1'b0;

    // reset, with start asserted: rst must win
    if8.start = 1'b1;
    tick(); tick();
    chk("rst_busy", 64'(if8.busy), 64'd0);
    chk("rst_done", 64'(if8.done), 64'd0);
    chk("rst_sum", 64'(if8.Sum), 64'd0);
    chk("rst_cout", 64'(if8.C_out), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 64'(if8.OVF), 64'd0);
`endif
    if8.start = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(if8.busy), 64'd0);

    run_op(1'b0, 32'h00, 32'h00, 1'b0, "zero");
    run_op(1'b0, 32'hFF, 32'h01, 1'b0, "ff_p1");

    // back-to-back with start held high
    if8.start = 1'b1; if8.A = 8'hA5; if8.B = 8'h5A; if8.C_in = 1'b1;
    first_done = 0; second_done = 0;
    for (int c = 0; c < 40 && second_done == 0; c++) begin
      if (if8.done) begin
        chk("b2b_sum", 64'(if8.Sum), 64'h00);
        chk("b2b_cout", 64'(if8.C_out), 64'd1);
        if (first_done == 0) first_done = c;
        else                 second_done = c;
      end
      if (second_done == 0) tick();
    end
    tick();
    if8.start = 1'b0;
    chk("b2b_first", 64'(first_done), 64'd9);
    chk("b2b_gap", 64'(second_done - first_done), 64'd10);
    tick();
    chk("b2b_idle", 64'(if8.busy), 64'd0);

    // start pulses in cycles 3 and 9 are ignored
    if8.start = 1'b1; if8.A = 8'h12; if8.B = 8'h34; if8.C_in = 1'b0;
    tick();
    if8.start = 1'b0; if8.A = 8'hEE; if8.B = 8'hEE;
    dones = 0;
    for (int c = 1; c <= 9; c++) begin
      if (if8.done) begin
        dones++;
        chk("ign_done_cyc", 64'(c), 64'd9);
      end
      if (c == 3 || c == 9) if8.start = 1'b1;
      if (c == 9) begin
        chk("ign_sum", 64'(if8.Sum), 64'h46);
        chk("ign_cout", 64'(if8.C_out), 64'd0);
      end
      tick();
      if8.start = 1'b0;
    end
    chk("ign_one_done", 64'(dones), 64'd1);
    chk("ign_idle", 64'(if8.busy), 64'd0);
    dones = 0;
    for (int c = 0; c < 14; c++) begin
      if (if8.done) dones++;
      tick();
    end
    chk("ign_no_second", 64'(dones), 64'd0);

    // reset mid-RUN discards the operation
    if8.start = 1'b1; if8.A = 8'h0F; if8.B = 8'h01; if8.C_in = 1'b0;
    tick();
    if8.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 64'(if8.busy), 64'd0);
    chk("mrst_sum", 64'(if8.Sum), 64'd0);
    chk("mrst_cout", 64'(if8.C_out), 64'd0);
    chk("mrst_done", 64'(if8.done), 64'd0);
    dones = 0;
    for (int c = 0; c < 14; c++) begin
      if (if8.done) dones++;
      tick();
    end
    chk("mrst_no_done", 64'(dones), 64'd0);
    run_op(1'b0, 32'h0F, 32'h01, 1'b0, "post_rst");

    run_op(1'b0, 32'h7F, 32'h01, 1'b0, "ovf_7f");
    run_op(1'b0, 32'h80, 32'h80, 1'b0, "ovf_80");
    run_op(1'b0, 32'h7F, 32'h00, 1'b1, "ovf_cin");

    for (int i = 0; i < 40; i++)
      run_op(1'b0, $urandom_range(255, 0), $urandom_range(255, 0),
             1'($urandom_range(1, 0)), "rand8");

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int ci = 0; ci < 2; ci++)
          run_op(1'b1, 32'(a), 32'(b), 1'(ci), "exh2");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
